imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Instruction-memory responder on the processor's fetch side. It takes the 16-bit program counter and returns the 32-bit instruction word.
- Also owns a byte-serial program-load port, driven by a host or UART bridge.
- Holds the processor in reset until a program image has been loaded.
- The processor's pc/instr pair is the client of this block.

Parameters:
ADDR_W, 8, word-address width; memory depth = 2**ADDR_W 32-bit words
OOR_INSTR, 32'h0000_0000, word returned for out-of-range or not-running fetches

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
pc  input  16  word-addressed program counter from processor
instr  output  32  instruction word to processor
load_start  input  1  begin a new image load
load_valid  input  1  load_byte valid this cycle
load_byte  input  8  image byte
load_last  input  1  qualifies load_valid; marks the final byte of the image
load_ready  output  1  block accepts load_byte this cycle
cpu_reset  output  1  reset to processor; high while not in RUN
load_done  output  1  one-cycle pulse on LOAD->RUN
load_err  output  1  sticky overflow flag
words_loaded  output  ADDR_W+1  number of words written by the last load

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- States: HOLD, LOAD, RUN. Reset -> HOLD.
- Reset values: cpu_reset=1, load_ready=0, load_done=0, load_err=0, words_loaded=0, byte index=0, write address=0.
- RAM contents are not cleared by reset. Simulation initialises RAM to 0.
- HOLD: cpu_reset=1, load_ready=0. load_start -> LOAD.
- RUN: cpu_reset=0. load_start -> LOAD, and cpu_reset asserts in the same cycle as the transition.
- Entering LOAD: byte index=0, write address=0, load_err=0, words_loaded=0.
- LOAD: load_ready=1. A byte is accepted on load_valid && load_ready.
  - Byte order is big-endian: 1st byte -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
  - On the 4th accepted byte, the assembled word is written to mem[addr] in that same clock edge; addr increments and the byte index returns to 0.
- load_last with an accepted byte:
  - A partial word is written with the unfilled low bytes zero-padded.
  - words_loaded = final word count.
  - State -> RUN; load_done pulses for one cycle.
  - load_last with an empty word cannot occur (load_last always accompanies a byte).
- Overflow: a word write when addr == 2**ADDR_W sets load_err. The write is discarded and addr saturates. Loading continues until load_last, then -> RUN.
- load_start during LOAD restarts the load (addr=0, index=0). Any partial word is discarded.
- load_valid outside LOAD is ignored.
- Fetch is combinational:
  - RUN and pc < 2**ADDR_W: instr = mem[pc[ADDR_W-1:0]].
  - Otherwise: instr = OOR_INSTR.
- A write and a read of the same address in one cycle cannot occur; fetch is gated off in LOAD.
- Reset mid-load returns to HOLD. Words already written remain in RAM.

Optional Feature:
- IMEM_CHECKSUM_EN defined:
  - Adds output checksum[15:0]: a 16-bit wrapping sum of every accepted load_byte.
  - Cleared on reset and on entering LOAD; holds its value in RUN.
- Undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset, no load -> cpu_reset=1, instr=OOR_INSTR for pc=0, load_ready=0.
- load_start, then bytes 12 34 56 78 AB CD EF 01 with load_last on the final byte ->
  - mem[0]=32'h12345678, mem[1]=32'hABCDEF01, words_loaded=2, one load_done pulse.
  - Next cycle cpu_reset=0; pc=1 gives instr=32'hABCDEF01.
- Partial word: bytes DE AD with load_last -> mem[0]=32'hDEAD0000, words_loaded=1.
- ADDR_W=2, load 5 words (20 bytes) -> load_err=1, words 0..3 written, mem unchanged otherwise, words_loaded=4, RUN reached.
- In RUN, fetch pc=16'h0100 with ADDR_W=8 -> OOR_INSTR; load_start mid-RUN -> cpu_reset=1 the same cycle.
- Reset asserted after 2 bytes of a load -> HOLD, cpu_reset=1, load_ready=0; a reload then starts at word 0.

Source files
------------

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : instruction memory with byte-serial image loader; optional
//               IMEM_CHECKSUM_EN adds a 16-bit sum of accepted bytes. Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] OOR_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pc,
  output logic [31:0]       instr,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
`ifdef IMEM_CHECKSUM_EN
  , output logic [15:0]     checksum
`endif
);

  localparam int              DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [23:0]       buf_q, buf_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              we;
  logic [31:0]       wdata;
  logic [ADDR_W:0]   addr_nxt;
  logic [31:0]       mem_q [DEPTH];
`ifdef IMEM_CHECKSUM_EN
  logic [15:0]       cks_q, cks_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    wl_d     = wl_q;
    err_d    = err_q;
    done_d   = 1'b0;
    we       = 1'b0;
    addr_nxt = (addr_q == FULL) ? FULL : addr_q + 1'b1;
`ifdef IMEM_CHECKSUM_EN
    cks_d    = cks_q;
`endif
    // Low bytes not yet received are zero so a short final word is padded.
    case (idx_q)
      2'd0:    wdata = {load_byte, 24'h0};
      2'd1:    wdata = {buf_q[23:16], load_byte, 16'h0};
      2'd2:    wdata = {buf_q[23:8], load_byte, 8'h0};
      default: wdata = {buf_q, load_byte};
    endcase

    // load_start from any state (re)starts an image; it wins over a byte.
    if (load_start) begin
      state_d = LOAD;
      idx_d   = 2'd0;
      addr_d  = '0;
      err_d   = 1'b0;
      wl_d    = '0;
`ifdef IMEM_CHECKSUM_EN
      cks_d   = '0;
`endif
    end else if (state_q == LOAD && load_valid) begin
`ifdef IMEM_CHECKSUM_EN
      cks_d = cks_q + {8'h00, load_byte};
`endif
      case (idx_q)
        2'd0:    buf_d[23:16] = load_byte;
        2'd1:    buf_d[15:8]  = load_byte;
        default: buf_d[7:0]   = load_byte;
      endcase
      if (idx_q == 2'd3 || load_last) begin
        if (addr_q == FULL) err_d = 1'b1;
        else                we    = 1'b1;
        addr_d = addr_nxt;
        idx_d  = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
      if (load_last) begin
        wl_d    = addr_nxt;
        state_d = RUN;
        done_d  = 1'b1;
      end
    end else if (state_q != HOLD && state_q != LOAD && state_q != RUN) begin
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      idx_q   <= 2'd0;
      addr_q  <= '0;
      buf_q   <= '0;
      wl_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      wl_q    <= wl_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef IMEM_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  // RAM survives reset so a reset mid-load keeps already written words.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr_q[ADDR_W-1:0]] <= wdata;
  end

  assign instr        = (state_q == RUN && (pc >> ADDR_W) == 16'd0)
                        ? mem_q[pc[ADDR_W-1:0]] : OOR_INSTR;
  assign cpu_reset    = reset | load_start | (state_q != RUN);
  assign load_ready   = (state_q == LOAD) && !load_start;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = wl_q;
`ifdef IMEM_CHECKSUM_EN
  assign checksum     = cks_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : scoreboard bench for imem_loader (ADDR_W=8 and ADDR_W=2
//                  instances on shared stimulus). Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int S_INSTR_A  = 0;
  localparam int S_INSTR_B  = 1;
  localparam int S_CPURST_A = 2;
  localparam int S_CPURST_B = 3;
  localparam int S_READY_A  = 4;
  localparam int S_DONE_A   = 5;
  localparam int S_ERR_A    = 6;
  localparam int S_ERR_B    = 7;
  localparam int S_WL_A     = 8;
  localparam int S_WL_B     = 9;
  localparam int S_CKS_A    = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        load_start, load_valid, load_last;
  logic [7:0]  load_byte;

  logic [31:0] instr_a, instr_b;
  logic        ready_a, ready_b, cpurst_a, cpurst_b;
  logic        done_a, done_b, err_a, err_b;
  logic [8:0]  wl_a;
  logic [2:0]  wl_b;
`ifdef IMEM_CHECKSUM_EN
  logic [15:0] cks_a, cks_b;
`endif

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } probe_t;

  probe_t pq[$];
  int     done_qa[$];
  int     done_qb[$];
  logic   probe_vld;
  int     n_chk;
  int     n_fail;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .OOR_INSTR(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr_a),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(ready_a), .cpu_reset(cpurst_a),
    .load_done(done_a), .load_err(err_a), .words_loaded(wl_a)
`ifdef IMEM_CHECKSUM_EN
    , .checksum(cks_a)
`endif
  );

  imem_loader #(.ADDR_W(2), .OOR_INSTR(32'h0000_0000)) dut_b (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr_b),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_last(load_last), .load_ready(ready_b), .cpu_reset(cpurst_b),
    .load_done(done_b), .load_err(err_b), .words_loaded(wl_b)
`ifdef IMEM_CHECKSUM_EN
    , .checksum(cks_b)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_INSTR_A:  return instr_a;
      S_INSTR_B:  return instr_b;
      S_CPURST_A: return {31'd0, cpurst_a};
      S_CPURST_B: return {31'd0, cpurst_b};
      S_READY_A:  return {31'd0, ready_a};
      S_DONE_A:   return {31'd0, done_a};
      S_ERR_A:    return {31'd0, err_a};
      S_ERR_B:    return {31'd0, err_b};
      S_WL_A:     return {23'd0, wl_a};
      S_WL_B:     return {29'd0, wl_b};
`ifdef IMEM_CHECKSUM_EN
      S_CKS_A:    return {16'd0, cks_a};
`endif
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: load_done pulses and probe strobes pop the scoreboard queues.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (done_qa.size() == 0) check("unexpected_done_a", 32'd1, 32'd0);
      else check("done_words_loaded_a", {23'd0, wl_a}, 32'(done_qa.pop_front()));
    end
    if (done_b === 1'b1) begin
      if (done_qb.size() == 0) check("unexpected_done_b", 32'd1, 32'd0);
      else check("done_words_loaded_b", {29'd0, wl_b}, 32'(done_qb.pop_front()));
    end
    if (probe_vld) begin
      while (pq.size() > 0) begin
        probe_t p;
        p = pq.pop_front();
        check(p.name, observe(p.sel), p.exp);
      end
    end
  end

  function automatic void expect_val(input string name, input int sel, input logic [31:0] exp);
    probe_t p;
    p.name = name;
    p.sel  = sel;
    p.exp  = exp;
    pq.push_back(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe_cycle();
    probe_vld = 1'b1;
    tick();
    probe_vld = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  logic [31:0] ovf_words [5];
  logic [7:0]  img1 [8];

  initial begin
    n_chk = 0; n_fail = 0; probe_vld = 1'b0;
    reset = 1'b1; pc = 16'd0;
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_byte = 8'h00;
    img1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    ovf_words = '{32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F, 32'h20212223};
    tick(); tick();
    reset = 1'b0;

    // Reset state, nothing loaded
    expect_val("rst_cpu_reset", S_CPURST_A, 32'd1);
    expect_val("rst_load_ready", S_READY_A, 32'd0);
    expect_val("rst_instr_oor", S_INSTR_A, 32'h0);
    expect_val("rst_words_loaded", S_WL_A, 32'd0);
    expect_val("rst_load_err", S_ERR_A, 32'd0);
    expect_val("rst_load_done", S_DONE_A, 32'd0);
    probe_cycle();

    // Two-word image
    start_load();
    expect_val("load_ready_in_load", S_READY_A, 32'd1);
    expect_val("cpu_reset_in_load", S_CPURST_A, 32'd1);
    expect_val("instr_gated_in_load", S_INSTR_A, 32'h0);
    probe_vld = 1'b1;
    done_qa.push_back(2);
    done_qb.push_back(2);
    for (int i = 0; i < 8; i++) begin
      send(img1[i], i == 7);
      probe_vld = 1'b0;
    end
    pc = 16'd1;
    expect_val("run_cpu_reset", S_CPURST_A, 32'd0);
    expect_val("run_pc1_a", S_INSTR_A, 32'hABCDEF01);
    expect_val("run_pc1_b", S_INSTR_B, 32'hABCDEF01);
    expect_val("run_words_loaded", S_WL_A, 32'd2);
    expect_val("run_done_pulse", S_DONE_A, 32'd1);
`ifdef IMEM_CHECKSUM_EN
    expect_val("checksum_img1", S_CKS_A, 32'h0000037C);
`endif
    probe_cycle();
    pc = 16'd0;
    expect_val("run_pc0_a", S_INSTR_A, 32'h12345678);
    expect_val("run_pc0_b", S_INSTR_B, 32'h12345678);
    expect_val("done_one_cycle", S_DONE_A, 32'd0);
    probe_cycle();

    // Out-of-range fetches
    pc = 16'h0100;
    expect_val("oor_pc100_a", S_INSTR_A, 32'h0);
    expect_val("oor_pc100_b", S_INSTR_B, 32'h0);
    probe_cycle();
    pc = 16'h0004;
    expect_val("oor_pc4_b", S_INSTR_B, 32'h0);
    probe_cycle();

    // load_start while running raises cpu_reset in that same cycle
    load_start = 1'b1;
    expect_val("restart_cpu_reset_same_cycle", S_CPURST_A, 32'd1);
    probe_cycle();
    load_start = 1'b0;

    // Partial word
    done_qa.push_back(1);
    done_qb.push_back(1);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b1);
    pc = 16'd0;
    expect_val("partial_pc0", S_INSTR_A, 32'hDEAD0000);
    expect_val("partial_words_loaded", S_WL_A, 32'd1);
    expect_val("partial_err", S_ERR_A, 32'd0);
    probe_cycle();
    pc = 16'd1;
    expect_val("partial_pc1_retained", S_INSTR_A, 32'hABCDEF01);
    probe_cycle();

    // Overflow on the 4-word instance
    start_load();
    done_qa.push_back(5);
    done_qb.push_back(4);
    for (int i = 0; i < 20; i++) send(8'(8'h10 + i), i == 19);
    expect_val("ovf_err_b", S_ERR_B, 32'd1);
    expect_val("ovf_wl_b", S_WL_B, 32'd4);
    expect_val("ovf_run_b", S_CPURST_B, 32'd0);
    expect_val("ovf_err_a", S_ERR_A, 32'd0);
    expect_val("ovf_wl_a", S_WL_A, 32'd5);
    probe_cycle();
    for (int k = 0; k < 4; k++) begin
      pc = 16'(k);
      expect_val("ovf_word_b", S_INSTR_B, ovf_words[k]);
      expect_val("ovf_word_a", S_INSTR_A, ovf_words[k]);
      probe_cycle();
    end
    pc = 16'd4;
    expect_val("ovf_word4_a", S_INSTR_A, ovf_words[4]);
    expect_val("ovf_err_sticky_b", S_ERR_B, 32'd1);
    probe_cycle();

    // Reset in the middle of a load, then reload from word 0
    start_load();
    expect_val("err_cleared_on_load_b", S_ERR_B, 32'd0);
    probe_vld = 1'b1;
    send(8'h99, 1'b0);
    probe_vld = 1'b0;
    send(8'h88, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pc = 16'd0;
    expect_val("midrst_cpu_reset", S_CPURST_A, 32'd1);
    expect_val("midrst_load_ready", S_READY_A, 32'd0);
    expect_val("midrst_instr", S_INSTR_A, 32'h0);
    probe_cycle();
    start_load();
    done_qa.push_back(2);
    done_qb.push_back(2);
    send(8'hCA, 1'b0);
    send(8'hFE, 1'b0);
    send(8'hBA, 1'b0);
    send(8'hBE, 1'b0);
    send(8'h77, 1'b1);
    expect_val("reload_pc0_a", S_INSTR_A, 32'hCAFEBABE);
    expect_val("reload_err_b", S_ERR_B, 32'd0);
    probe_cycle();
    pc = 16'd1;
    expect_val("reload_pc1_a", S_INSTR_A, 32'h77000000);
    expect_val("reload_pc1_b", S_INSTR_B, 32'h77000000);
    probe_cycle();

    tick(); tick();
    check("done_pending_a", 32'(done_qa.size()), 32'd0);
    check("done_pending_b", 32'(done_qb.size()), 32'd0);
    check("probe_pending", 32'(pq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
